// File: rtl/fpnew_classify_arbiter.sv
// ---------------------------------------------------------------------------
// fpnew_classify_arbiter
//
// Purpose:
//   Shares one floating-point classifier (FCLASS) between NumReq requesters.
//   Each cycle a round-robin arbiter picks one valid requester, and its
//   operand goes through the single classifier. The class mask, the
//   classification info, the requester index and the tag are stored in a
//   one-deep output register with a valid/ready handshake.
//
// Ports:
//   clk_i           rising-edge clock
//   rst_i           synchronous active-high reset
//   flush_i         synchronous discard of the held result
//   req_valid_i     per-requester request valid
//   req_ready_o     per-requester accept (one-hot or zero)
//   req_operand_i   per-requester operand
//   req_is_boxed_i  per-requester NaN-boxing status
//   req_tag_i       per-requester opaque tag
//   out_valid_o     held result valid
//   out_ready_i     downstream accept
//   out_class_o     RISC-V FCLASS one-hot mask
//   out_info_o      classification info of the held operand
//   out_id_o        index of the requester that produced the result
//   out_tag_o       tag of the held result
// ---------------------------------------------------------------------------

// Minimal format package: only the parts the classifier needs.
package fpnew_pkg;

   typedef enum logic [2:0] {
      FP32    = 3'd0,
      FP64    = 3'd1,
      FP16    = 3'd2,
      FP8     = 3'd3,
      FP16ALT = 3'd4
   } fp_format_e;

   typedef struct packed {
      logic is_normal;
      logic is_subnormal;
      logic is_zero;
      logic is_inf;
      logic is_nan;
      logic is_signalling;
      logic is_quiet;
      logic is_boxed;
   } fp_info_t;

   function automatic int unsigned exp_bits(fp_format_e fmt);
      case (fmt)
         FP64:    return 11;
         FP16:    return 5;
         FP8:     return 5;
         FP16ALT: return 8;
         default: return 8;
      endcase
   endfunction

   function automatic int unsigned man_bits(fp_format_e fmt);
      case (fmt)
         FP64:    return 52;
         FP16:    return 10;
         FP8:     return 2;
         FP16ALT: return 7;
         default: return 23;
      endcase
   endfunction

   function automatic int unsigned fp_width(fp_format_e fmt);
      return 1 + exp_bits(fmt) + man_bits(fmt);
   endfunction

endpackage

module fpnew_classify_arbiter #(
   parameter fpnew_pkg::fp_format_e FpFormat = fpnew_pkg::fp_format_e'(0),
   parameter int unsigned NumReq   = 4,
   parameter int unsigned TagWidth = 4,
   localparam int unsigned WIDTH    = fpnew_pkg::fp_width(FpFormat),
   localparam int unsigned IdxWidth = ($clog2(NumReq) > 1) ? $clog2(NumReq) : 1
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               flush_i,
   input  logic [NumReq-1:0]                  req_valid_i,
   output logic [NumReq-1:0]                  req_ready_o,
   input  logic [NumReq-1:0][WIDTH-1:0]       req_operand_i,
   input  logic [NumReq-1:0]                  req_is_boxed_i,
   input  logic [NumReq-1:0][TagWidth-1:0]    req_tag_i,
   output logic                               out_valid_o,
   input  logic                               out_ready_i,
   output logic [9:0]                         out_class_o,
   output fpnew_pkg::fp_info_t                out_info_o,
   output logic [IdxWidth-1:0]                out_id_o,
   output logic [TagWidth-1:0]                out_tag_o
);

   localparam int unsigned ExpBits = fpnew_pkg::exp_bits(FpFormat);
   localparam int unsigned ManBits = fpnew_pkg::man_bits(FpFormat);

   logic [IdxWidth-1:0] rr_ptr;
   logic [IdxWidth-1:0] grant_idx;
   logic [IdxWidth:0]   scan_sum;
   logic                grant_found;
   logic                stage_free;
   logic                handshake;

   logic [WIDTH-1:0]    sel_operand;
   logic                sel_boxed;
   logic [TagWidth-1:0] sel_tag;
   logic                sign;
   logic [ExpBits-1:0]  exponent;
   logic [ManBits-1:0]  mantissa;
   logic                exp_ones;
   logic                exp_zero;
   logic                man_zero;
   logic [9:0]          class_mask;
   fpnew_pkg::fp_info_t class_info;

   // Stage can take a new operand when the slot is empty or being drained.
   // Reset also blocks acceptance so nothing is handshaken while it is held.
   assign stage_free = (!out_valid_o || out_ready_i) && !flush_i && !rst_i;

   // Round-robin scan: visit indices rr_ptr, rr_ptr+1, ... wrapping at NumReq,
   // and take the first one that is requesting. The sum is one bit wider than
   // the index so the wrap comparison against NumReq cannot overflow.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_sum    = '0;
      for (int i = 0; i < NumReq; i++) begin
         scan_sum = {1'b0, rr_ptr} + (IdxWidth+1)'(i);
         if (scan_sum >= (IdxWidth+1)'(NumReq)) begin
            scan_sum = scan_sum - (IdxWidth+1)'(NumReq);
         end
         if (!grant_found && req_valid_i[scan_sum[IdxWidth-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = scan_sum[IdxWidth-1:0];
         end
      end
   end

   assign handshake = grant_found && stage_free;

   // Only the granted requester ever sees ready, and only when it will be taken.
   always_comb begin
      req_ready_o = '0;
      if (handshake) begin
         req_ready_o[grant_idx] = 1'b1;
      end
   end

   // Single shared classifier datapath, fed through the grant mux.
   assign sel_operand = req_operand_i[grant_idx];
   assign sel_boxed   = req_is_boxed_i[grant_idx];
   assign sel_tag     = req_tag_i[grant_idx];

   assign sign     = sel_operand[WIDTH-1];
   assign exponent = sel_operand[WIDTH-2 -: ExpBits];
   assign mantissa = sel_operand[ManBits-1:0];
   assign exp_ones = &exponent;
   assign exp_zero = ~|exponent;
   assign man_zero = ~|mantissa;

   // An operand that is not properly NaN-boxed is treated as the canonical
   // quiet NaN, whatever its bits say. NaN classes ignore the sign.
   always_comb begin
      class_mask = '0;
      class_info = '0;
      if (!sel_boxed) begin
         class_info.is_nan   = 1'b1;
         class_info.is_quiet = 1'b1;
         class_mask[9]       = 1'b1;
      end else if (exp_ones && man_zero) begin
         class_info.is_inf = 1'b1;
         if (sign) class_mask[0] = 1'b1;
         else      class_mask[7] = 1'b1;
      end else if (exp_ones) begin
         class_info.is_nan = 1'b1;
         if (mantissa[ManBits-1]) begin
            class_info.is_quiet = 1'b1;
            class_mask[9]       = 1'b1;
         end else begin
            class_info.is_signalling = 1'b1;
            class_mask[8]            = 1'b1;
         end
      end else if (exp_zero && man_zero) begin
         class_info.is_zero = 1'b1;
         if (sign) class_mask[3] = 1'b1;
         else      class_mask[4] = 1'b1;
      end else if (exp_zero) begin
         class_info.is_subnormal = 1'b1;
         if (sign) class_mask[2] = 1'b1;
         else      class_mask[5] = 1'b1;
      end else begin
         class_info.is_normal = 1'b1;
         if (sign) class_mask[1] = 1'b1;
         else      class_mask[6] = 1'b1;
      end
      class_info.is_boxed = sel_boxed;
   end

   // Output register and round-robin pointer. Reset beats flush, flush beats
   // a handshake; a handshake in a draining cycle replaces the result with
   // no bubble. Flush only drops valid and leaves the pointer alone.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_o <= 1'b0;
         out_class_o <= '0;
         out_info_o  <= '0;
         out_id_o    <= '0;
         out_tag_o   <= '0;
         rr_ptr      <= '0;
      end else if (flush_i) begin
         out_valid_o <= 1'b0;
      end else if (handshake) begin
         out_valid_o <= 1'b1;
         out_class_o <= class_mask;
         out_info_o  <= class_info;
         out_id_o    <= grant_idx;
         out_tag_o   <= sel_tag;
         rr_ptr      <= (grant_idx == IdxWidth'(NumReq-1)) ? '0
                                                          : grant_idx + IdxWidth'(1);
      end else if (out_ready_i) begin
         out_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fpnew_classify_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpnew_classify_arbiter
//
// Purpose:
//   Directed bench for fpnew_classify_arbiter (FP32, 4 requesters, 4-bit
//   tags). A behavioural model tracks the held result and the round-robin
//   pointer; a compare process checks the DUT against it on every falling
//   edge, and the directed sequence pins a set of literal expectations.
// ---------------------------------------------------------------------------
module tb_fpnew_classify_arbiter;

   localparam int N = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                flush;
   logic [N-1:0]        req_valid;
   logic [N-1:0]        req_ready;
   logic [N-1:0][31:0]  req_operand;
   logic [N-1:0]        req_is_boxed;
   logic [N-1:0][3:0]   req_tag;
   logic                out_valid;
   logic                out_ready;
   logic [9:0]          out_class;
   fpnew_pkg::fp_info_t out_info;
   logic [1:0]          out_id;
   logic [3:0]          out_tag;

   int error_count = 0;
   int check_count = 0;

   fpnew_classify_arbiter dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .flush_i        (flush),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_operand_i  (req_operand),
      .req_is_boxed_i (req_is_boxed),
      .req_tag_i      (req_tag),
      .out_valid_o    (out_valid),
      .out_ready_i    (out_ready),
      .out_class_o    (out_class),
      .out_info_o     (out_info),
      .out_id_o       (out_id),
      .out_tag_o      (out_tag)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Model state: what the output register must hold and where the
   // round-robin pointer must be.
   int         m_ptr   = 0;
   logic       m_valid = 1'b0;
   logic [9:0] m_class = '0;
   logic [7:0] m_info  = '0;
   int         m_id    = 0;
   logic [3:0] m_tag   = '0;

   // FCLASS bit position of a single-precision value.
   function automatic int classIndex(input logic [31:0] op, input logic boxed);
      int unsigned sgn, e, f;
      sgn = op >> 31;
      e   = (op >> 23) & 32'hFF;
      f   = op & 32'h7FFFFF;
      if (!boxed)       return 9;
      if (e == 255) begin
         if (f == 0)    return (sgn != 0) ? 0 : 7;
         return (f >= 32'h400000) ? 9 : 8;
      end
      if (e == 0) begin
         if (f == 0)    return (sgn != 0) ? 3 : 4;
         return (sgn != 0) ? 2 : 5;
      end
      return (sgn != 0) ? 1 : 6;
   endfunction

   // Info flags follow from the class position.
   function automatic logic [7:0] infoOf(input int idx, input logic boxed);
      logic [7:0] r;
      r[7] = (idx == 1 || idx == 6);
      r[6] = (idx == 2 || idx == 5);
      r[5] = (idx == 3 || idx == 4);
      r[4] = (idx == 0 || idx == 7);
      r[3] = (idx == 8 || idx == 9);
      r[2] = (idx == 8);
      r[1] = (idx == 9);
      r[0] = boxed;
      return r;
   endfunction

   // First requesting index at or after the pointer, wrapping; -1 if none.
   function automatic int expGrant();
      for (int k = 0; k < N; k++) begin
         if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [3:0] expReady();
      int g;
      if (rst || flush || (m_valid && !out_ready)) return 4'b0000;
      g = expGrant();
      if (g < 0) return 4'b0000;
      return 4'(1 << g);
   endfunction

   // Model update on each rising edge, from the inputs just before the edge.
   always @(posedge clk) begin
      int         g;
      logic [3:0] rdy;
      rdy = expReady();
      g   = expGrant();
      if (rst) begin
         m_valid = 1'b0;
         m_class = '0;
         m_info  = '0;
         m_id    = 0;
         m_tag   = '0;
         m_ptr   = 0;
      end else if (flush) begin
         m_valid = 1'b0;
      end else if (rdy != 4'b0000) begin
         m_valid = 1'b1;
         m_class = 10'(1 << classIndex(req_operand[g], req_is_boxed[g]));
         m_info  = infoOf(classIndex(req_operand[g], req_is_boxed[g]), req_is_boxed[g]);
         m_id    = g;
         m_tag   = req_tag[g];
         m_ptr   = (g + 1) % N;
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      checkOutput("model_ready", 32'(req_ready), 32'(expReady()));
      checkOutput("model_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
         checkOutput("model_class", 32'(out_class), 32'(m_class));
         checkOutput("model_info",  32'(out_info),  32'(m_info));
         checkOutput("model_id",    32'(out_id),    32'(m_id));
         checkOutput("model_tag",   32'(out_tag),   32'(m_tag));
      end
   end

   task automatic setRequester(input int idx, input logic [31:0] op,
                               input logic boxed, input logic [3:0] tag);
      req_operand[idx]  = op;
      req_is_boxed[idx] = boxed;
      req_tag[idx]      = tag;
   endtask

   task automatic applyStimulus(input logic [3:0] valid, input logic ordy,
                                input logic fl, input logic rs);
      req_valid = valid;
      out_ready = ordy;
      flush     = fl;
      rst       = rs;
      #1;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Safety net in case the run ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   logic [9:0] seq_class [4];

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0; req_valid = '0;
      req_operand = '0; req_is_boxed = '0; req_tag = '0;
      stepCycle();
      stepCycle();

      // Reset state, and no ready while reset is held even with requests.
      applyStimulus(4'b1111, 1'b1, 1'b0, 1'b1);
      checkOutput("reset_ready", 32'(req_ready), 32'h0);
      checkOutput("reset_valid", 32'(out_valid), 32'h0);
      checkOutput("reset_class", 32'(out_class), 32'h0);
      checkOutput("reset_info",  32'(out_info),  32'h0);
      checkOutput("reset_id",    32'(out_id),    32'h0);
      checkOutput("reset_tag",   32'(out_tag),   32'h0);
      stepCycle();

      // -inf from requester 0
      setRequester(0, 32'hFF800000, 1'b1, 4'd3);
      applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
      checkOutput("neginf_ready", 32'(req_ready), 32'h1);
      stepCycle();
      checkOutput("neginf_valid", 32'(out_valid), 32'h1);
      checkOutput("neginf_class", 32'(out_class), 32'h001);
      checkOutput("neginf_id",    32'(out_id),    32'h0);
      checkOutput("neginf_tag",   32'(out_tag),   32'h3);

      // sNaN from requester 1 (pointer now 1)
      setRequester(1, 32'h7FA00000, 1'b1, 4'd5);
      applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
      checkOutput("snan_ready", 32'(req_ready), 32'h2);
      stepCycle();
      checkOutput("snan_class", 32'(out_class), 32'h100);
      checkOutput("snan_id",    32'(out_id),    32'h1);
      checkOutput("snan_tag",   32'(out_tag),   32'h5);

      // qNaN from requester 1 (pointer 2, scan wraps back to 1)
      setRequester(1, 32'h7FC00000, 1'b1, 4'd5);
      applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
      checkOutput("qnan_ready", 32'(req_ready), 32'h2);
      stepCycle();
      checkOutput("qnan_class", 32'(out_class), 32'h200);

      // +subnormal from requester 2
      setRequester(2, 32'h00000001, 1'b1, 4'd9);
      applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
      stepCycle();
      checkOutput("psub_class", 32'(out_class), 32'h020);
      checkOutput("psub_id",    32'(out_id),    32'h2);
      checkOutput("psub_tag",   32'(out_tag),   32'h9);

      // Unboxed operand from requester 2: canonical qNaN, is_boxed clear
      setRequester(2, 32'h3F800000, 1'b0, 4'd9);
      applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
      stepCycle();
      checkOutput("unboxed_class", 32'(out_class), 32'h200);
      checkOutput("unboxed_info",  32'(out_info),  32'h0A);

      // No request, downstream ready: valid drops
      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
      stepCycle();
      checkOutput("drain_valid", 32'(out_valid), 32'h0);

      // Reset, then all four requesters continuously valid
      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1);
      stepCycle();
      setRequester(0, 32'h3F800000, 1'b1, 4'd1);
      setRequester(1, 32'h80000000, 1'b1, 4'd2);
      setRequester(2, 32'h807FFFFF, 1'b1, 4'd3);
      setRequester(3, 32'h7F800000, 1'b1, 4'd4);
      seq_class[0] = 10'h040;
      seq_class[1] = 10'h008;
      seq_class[2] = 10'h004;
      seq_class[3] = 10'h080;
      applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         stepCycle();
         checkOutput("rr_valid", 32'(out_valid), 32'h1);
         checkOutput("rr_id",    32'(out_id),    32'(k % 4));
         checkOutput("rr_class", 32'(out_class), 32'(seq_class[k % 4]));
      end

      // Stall: requester 1's result held for 5 cycles, pointer at 2
      applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
      checkOutput("stall_ready", 32'(req_ready), 32'h0);
      for (int k = 0; k < 5; k++) begin
         stepCycle();
         checkOutput("stall_valid", 32'(out_valid), 32'h1);
         checkOutput("stall_id",    32'(out_id),    32'h1);
         checkOutput("stall_class", 32'(out_class), 32'h008);
         checkOutput("stall_tag",   32'(out_tag),   32'h2);
         checkOutput("stall_ready", 32'(req_ready), 32'h0);
      end
      applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
      checkOutput("unstall_ready", 32'(req_ready), 32'h4);
      stepCycle();
      checkOutput("unstall_id",    32'(out_id),    32'h2);
      checkOutput("unstall_class", 32'(out_class), 32'h004);

      // Flush while valid: no ready this cycle, valid gone next, pointer kept at 3
      applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0);
      checkOutput("flush_ready", 32'(req_ready), 32'h0);
      stepCycle();
      applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
      checkOutput("flush_valid", 32'(out_valid), 32'h0);
      checkOutput("postflush_ready", 32'(req_ready), 32'h8);
      stepCycle();
      checkOutput("postflush_id", 32'(out_id), 32'h3);
      stepCycle();
      checkOutput("wrap_id", 32'(out_id), 32'h0);
      stepCycle();
      checkOutput("wrap_next_id", 32'(out_id), 32'h1);

      // Reset mid-stream: outputs cleared, next grant goes to requester 0
      applyStimulus(4'b1111, 1'b1, 1'b0, 1'b1);
      checkOutput("midrst_ready", 32'(req_ready), 32'h0);
      stepCycle();
      checkOutput("midrst_valid", 32'(out_valid), 32'h0);
      checkOutput("midrst_class", 32'(out_class), 32'h0);
      checkOutput("midrst_info",  32'(out_info),  32'h0);
      checkOutput("midrst_id",    32'(out_id),    32'h0);
      checkOutput("midrst_tag",   32'(out_tag),   32'h0);
      applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
      checkOutput("afterrst_ready", 32'(req_ready), 32'h1);
      stepCycle();
      checkOutput("afterrst_id",    32'(out_id),    32'h0);
      checkOutput("afterrst_valid", 32'(out_valid), 32'h1);

      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
      stepCycle();
      stepCycle();

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
